// File: rtl/obf_par_rx.sv
// obf_par_rx: serial frame receiver (start, DATA_W data bits LSB first,
// even parity, stop) with parity and framing error flags.
// Ports: clk_i clock; rst_i sync active-high reset; rx_i serial line (idle 1);
//        dat_o received word; vld_o one-cycle frame-complete pulse;
//        perr_o parity error; ferr_o framing error; busy_o not idle.
// Optional: define OBF_PAR_RX_SYNC_EN to pass rx_i through a 2-flop
//           synchronizer (adds 2 cycles to every sample point and vld_o).
module obf_par_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              vld_o,
    output logic              perr_o,
    output logic              ferr_o,
    output logic              busy_o
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, WAITH
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] sh;
    logic              par_acc;
    logic              stop_bit;
    logic              done;
    logic              rx;
    logic              tick_half;
    logic              tick_bit;
    logic [DATA_W:0]   sh_ext;

`ifdef OBF_PAR_RX_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx_i};
        end
    end

    assign rx = sync[1];
`else
    assign rx = rx_i;
`endif

    assign tick_half = (cnt == CW'(HALF - 1));
    assign tick_bit  = (cnt == CW'(CLKS_PER_BIT - 1));
    // Shift right with the new bit entering at the MSB; works for DATA_W=1.
    assign sh_ext    = {rx, sh};

    // done covers the cycle between the stop sample and the vld_o pulse.
    assign busy_o = (state != IDLE) || done;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (!rx) state_n = START;
            START: if (tick_half) state_n = rx ? IDLE : DATA;
            DATA:  if (tick_bit && bit_cnt == BW'(DATA_W - 1)) state_n = PAR;
            PAR:   if (tick_bit) state_n = STOP;
            STOP:  if (tick_bit) state_n = rx ? IDLE : WAITH;
            WAITH: if (rx) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            par_acc  <= 1'b0;
            stop_bit <= 1'b0;
            done     <= 1'b0;
            dat_o    <= '0;
            vld_o    <= 1'b0;
            perr_o   <= 1'b0;
            ferr_o   <= 1'b0;
        end else begin
            state <= state_n;
            vld_o <= 1'b0;
            done  <= 1'b0;
            if (done) begin
                vld_o  <= 1'b1;
                dat_o  <= sh;
                perr_o <= par_acc;
                ferr_o <= ~stop_bit;
            end
            unique case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    par_acc <= 1'b0;
                end
                START: begin
                    cnt <= tick_half ? '0 : cnt + CW'(1);
                end
                DATA: begin
                    if (tick_bit) begin
                        cnt     <= '0;
                        sh      <= sh_ext[DATA_W:1];
                        par_acc <= par_acc ^ rx;
                        bit_cnt <= bit_cnt + BW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PAR: begin
                    if (tick_bit) begin
                        cnt     <= '0;
                        par_acc <= par_acc ^ rx;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (tick_bit) begin
                        cnt      <= '0;
                        stop_bit <= rx;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAITH: begin
                    cnt <= '0;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_obf_par_rx.sv
// tb_obf_par_rx: self-checking bench for obf_par_rx (default parameters).
// Expected frames go to a scoreboard queue and are checked on vld_o.
module tb_obf_par_rx;

    localparam int DW  = 8;
    localparam int CPB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [DW-1:0] dat;
    logic          vld;
    logic          perr;
    logic          ferr;
    logic          busy;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          p;
        logic          f;
        int            c;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    obf_par_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rx_i  (rx),
        .dat_o (dat),
        .vld_o (vld),
        .perr_o(perr),
        .ferr_o(ferr),
        .busy_o(busy)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one full frame (11 bit periods); stop level stays on the line.
    task automatic send(input logic [DW-1:0] d, input logic p,
                        input logic s, input bit push);
        exp_t e;
        if (push) begin
            e.d = d;
            e.p = (^d) ^ p;
            e.f = ~s;
            e.c = cyc + 170;
            q.push_back(e);
        end
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = p;
        tick(CPB);
        rx = s;
        tick(CPB);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (vld === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL vld_unexpected cyc=%0d dat=%h", cyc, dat);
                end else begin
                    e = q.pop_front();
                    checks += 4;
                    if (cyc !== e.c) begin
                        errors++;
                        $display("FAIL vld_time got=%0d exp=%0d", cyc, e.c);
                    end
                    if (dat !== e.d) begin
                        errors++;
                        $display("FAIL dat got=%h exp=%h", dat, e.d);
                    end
                    if (perr !== e.p) begin
                        errors++;
                        $display("FAIL perr got=%b exp=%b", perr, e.p);
                    end
                    if (ferr !== e.f) begin
                        errors++;
                        $display("FAIL ferr got=%b exp=%b", ferr, e.f);
                    end
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d exp=0", name, q.size());
            q.delete();
        end
        rx = 1'b1;
        tick(20);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        checks += 5;
        if (dat !== 8'h00) begin
            errors++;
            $display("FAIL rst_dat got=%h exp=00", dat);
        end
        if (vld !== 1'b0) begin
            errors++;
            $display("FAIL rst_vld got=%b exp=0", vld);
        end
        if (perr !== 1'b0) begin
            errors++;
            $display("FAIL rst_perr got=%b exp=0", perr);
        end
        if (ferr !== 1'b0) begin
            errors++;
            $display("FAIL rst_ferr got=%b exp=0", ferr);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got=%b exp=0", busy);
        end
        tick(5);
    endtask

    task automatic test_good_frame();
        fork
            send(8'hA5, 1'b0, 1'b1, 1'b1);
            begin
                tick(169);
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_before_vld got=%b exp=1", busy);
                end
                tick(1);
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_vld got=%b exp=0", busy);
                end
            end
        join
        drain("good");
    endtask

    task automatic test_parity_err();
        send(8'h07, 1'b0, 1'b1, 1'b1);
        drain("parity");
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        tick(1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_t0 got=%b exp=1", busy);
        end
        tick(3);
        rx = 1'b1;
        tick(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_t7 got=%b exp=1", busy);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_t8 got=%b exp=0", busy);
        end
        tick(200);
        checks += 2;
        if (dat !== 8'h07) begin
            errors++;
            $display("FAIL glitch_dat got=%h exp=07", dat);
        end
        if (perr !== 1'b1) begin
            errors++;
            $display("FAIL glitch_perr got=%b exp=1", perr);
        end
    endtask

    task automatic test_break();
        send(8'h3C, 1'b0, 1'b0, 1'b1);
        rx = 1'b0;
        tick(200);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL break_busy got=%b exp=1", busy);
        end
        rx = 1'b1;
        tick(16);
        send(8'h81, 1'b0, 1'b1, 1'b1);
        drain("break");
    endtask

    task automatic test_mid_reset();
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(3 * CPB + 8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks += 5;
        if (dat !== 8'h00) begin
            errors++;
            $display("FAIL mrst_dat got=%h exp=00", dat);
        end
        if (vld !== 1'b0) begin
            errors++;
            $display("FAIL mrst_vld got=%b exp=0", vld);
        end
        if (perr !== 1'b0) begin
            errors++;
            $display("FAIL mrst_perr got=%b exp=0", perr);
        end
        if (ferr !== 1'b0) begin
            errors++;
            $display("FAIL mrst_ferr got=%b exp=0", ferr);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mrst_busy got=%b exp=0", busy);
        end
        tick(200);
        send(8'h55, 1'b0, 1'b1, 1'b1);
        drain("mid_reset");
    endtask

    task automatic test_back_to_back();
        send(8'h12, 1'b0, 1'b1, 1'b1);
        send(8'h34, 1'b1, 1'b1, 1'b1);
        drain("b2b");
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_good_frame();
        test_parity_err();
        test_glitch();
        test_break();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/obf_par_rx.md
Name: obf_par_rx

Overview:
- Serial frame receiver with parity check; the receiving end of the XOR-reduction (even) parity generation used across the obfuscator test set.
- Deserialises start / DATA_W data bits LSB first / even parity / stop frames from a single-bit line.
- Flags parity and framing errors.
- Sits between a serial test-stimulus line and SBA-side logic consuming parallel words.

Parameters:
- DATA_W, 8: data bits per frame, 1..16.
- CLKS_PER_BIT, 16: clk_i cycles per bit, minimum 4. HALF = CLKS_PER_BIT/2 (integer division).

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- rx_i  input  1  serial line, idle high.
- dat_o  output  DATA_W  last received word.
- vld_o  output  1  one-cycle pulse: frame complete, dat_o/perr_o/ferr_o valid.
- perr_o  output  1  parity error of last frame.
- ferr_o  output  1  framing error (stop bit sampled 0) of last frame.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Interface (decided): one clock; rst_i is synchronous and active-high.
- Reset values: dat_o=0, vld_o=0, perr_o=0, ferr_o=0, busy_o=0, state=IDLE, counters=0.
- rst_i mid-frame aborts the frame, produces no vld_o, and returns to IDLE.
- States: IDLE, START, DATA, PAR, STOP, WAITH.
- Define t0 as the clock edge at which IDLE samples rx_i=0.
- IDLE: on rx_i=0 -> START, cycle counter cleared.
- START: samples rx_i at t0+HALF.
  - rx_i=0 -> DATA.
  - rx_i=1 -> IDLE (glitch rejected, no outputs change).
- DATA: data bit k (k=0..DATA_W-1) is sampled at t0+HALF+(k+1)*CLKS_PER_BIT and shifted in LSB first. After bit DATA_W-1 -> PAR.
- PAR: samples the parity bit at t0+HALF+(DATA_W+1)*CLKS_PER_BIT -> STOP.
- STOP: samples the stop bit at ts = t0+HALF+(DATA_W+2)*CLKS_PER_BIT.
- At ts+1:
  - vld_o=1 for exactly one cycle.
  - dat_o is loaded with the shifted word.
  - perr_o = XOR of the data bits XOR the parity bit (even parity; 1 = error).
  - ferr_o = NOT stop bit.
  - perr_o/ferr_o hold until the next vld_o or reset.
- After STOP:
  - stop bit=1 -> IDLE; a new start is accepted from ts+1 onward (mid stop bit), so back-to-back frames are supported.
  - stop bit=0 -> WAITH; stay until rx_i=1, then IDLE. A held-low line (break) never retriggers reception.
- dat_o is stable between vld_o pulses. No backpressure; the consumer must capture on vld_o.
- Latency with defaults (DATA_W=8, CLKS_PER_BIT=16): vld_o at t0+169.

Optional Feature:
- Macro: OBF_PAR_RX_SYNC_EN.
- Defined: rx_i passes through a 2-flop synchronizer, reset to 1, before the FSM. All sample times and vld_o shift 2 cycles later (defaults: t0_line+171, where t0_line is the edge on which the rx_i pin first reads 0).
- Undefined: rx_i is used directly; rx_i must already be synchronous to clk_i.

Test Plan:
- Frame 0xA5, parity 0, stop 1, defaults -> vld_o pulse at t0+169 only; dat_o=0xA5, perr_o=0, ferr_o=0; busy_o falls at t0+169.
- Frame 0x07, parity 0 (correct is 1), stop 1 -> vld_o pulse, dat_o=0x07, perr_o=1, ferr_o=0.
- rx_i low 4 cycles then high (glitch) -> no vld_o; busy_o high t0..t0+8 then 0; outputs unchanged.
- Frame 0x3C, parity 0, stop 0, rx_i held low 200 cycles, then high 16 cycles, then frame 0x81, parity 0 -> first vld_o with ferr_o=1, dat_o=0x3C; no vld_o during low hold; second vld_o with dat_o=0x81, ferr_o=0, perr_o=0.
- rst_i asserted one cycle during data bit 3 of 0xFF, line forced idle, then frame 0x55, parity 0 -> no vld_o for the aborted frame; all outputs 0 after reset; next vld_o gives dat_o=0x55, no errors.
- Back-to-back 0x12 (parity 0) and 0x34 (parity 1), second start beginning when the first stop bit ends -> two vld_o pulses exactly 176 cycles apart, both error-free, dat_o 0x12 then 0x34.
